phy_reset_seq: RTL and testbench

- Consumer of the clock generator's outputs. Runs on divclk and turns the raw `locked` flag into an ordered PHY bring-up: IDELAYCTRL reset, then wait for delay-control ready, then ISERDES/OSERDES reset release, then `phy_ready`.
- Any loss of lock tears the PHY back down and restarts the sequence.
- Sits between clock_gen and the DDR3 PHY datapath/calibration logic.

---
 rtl/phy_reset_seq_pkg.sv | 44 ++++
 rtl/phy_reset_seq_if.sv | 35 +++
 rtl/phy_reset_seq_sync_2ff.sv | 19 +
 rtl/phy_reset_seq.sv | 143 ++++++++++++++
 tb/tb_phy_reset_seq.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/phy_reset_seq_pkg.sv
// Shared types and default timing for the PHY reset sequencer (package phy_pkg).
// Holds the sequencer state encoding and the per-state reset/ready output map.
package phy_pkg;

    typedef enum logic [2:0] {
        HOLD       = 3'd0,
        FILTER     = 3'd1,
        IDC_RST    = 3'd2,
        WAIT_RDY   = 3'd3,
        SERDES_RST = 3'd4,
        READY      = 3'd5
    } seq_state_t;

    localparam int DEF_LOCK_FILT      = 16;
    localparam int DEF_IDC_RST_CYC    = 8;
    localparam int DEF_SERDES_RST_CYC = 4;
    localparam int DEF_RDY_TIMEOUT    = 1024;
    localparam int DEF_CNT_W          = 8;

    typedef struct packed {
        logic idc_rst;
        logic serdes_rst;
        logic ready;
    } phy_ctl_t;

    // Reset/ready levels the PHY sees while the sequencer sits in a given state.
    function automatic phy_ctl_t ctl_for(seq_state_t s);
        phy_ctl_t c;
        c = '{idc_rst: 1'b1, serdes_rst: 1'b1, ready: 1'b0};
        case (s)
            WAIT_RDY, SERDES_RST: c.idc_rst = 1'b0;
            READY:                c = '{idc_rst: 1'b0, serdes_rst: 1'b0, ready: 1'b1};
            default:              ;
        endcase
        return c;
    endfunction

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phy_reset_seq_if.sv
// Sequencer-to-PHY signal bundle: lock/ready inputs plus reset, ready and debug outputs.
interface phy_reset_seq_if #(
    parameter int CNT_W = 8
);
    logic             locked;
    logic             idelay_rdy;
    logic             idelayctrl_rst;
    logic             serdes_rst;
    logic             phy_ready;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [2:0]       seq_state;
    logic             rdy_timeout;

    modport master (
        output locked,
        output idelay_rdy,
        input  idelayctrl_rst,
        input  serdes_rst,
        input  phy_ready,
        input  lock_loss_cnt,
        input  seq_state,
        input  rdy_timeout
    );

    modport slave (
        input  locked,
        input  idelay_rdy,
        output idelayctrl_rst,
        output serdes_rst,
        output phy_ready,
        output lock_loss_cnt,
        output seq_state,
        output rdy_timeout
    );
endinterface

// File: rtl/phy_reset_seq_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-low clear.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/phy_reset_seq.sv
// Orders PHY bring-up from clock_gen lock: IDELAYCTRL reset, RDY wait, SERDES reset, ready.
// Optional WAIT_RDY timeout is built when PHY_RST_TIMEOUT_EN is defined.
module phy_reset_seq
    import phy_pkg::*;
#(
    parameter int LOCK_FILT      = DEF_LOCK_FILT,
    parameter int IDC_RST_CYC    = DEF_IDC_RST_CYC,
    parameter int SERDES_RST_CYC = DEF_SERDES_RST_CYC,
    parameter int RDY_TIMEOUT    = DEF_RDY_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input logic             clk,
    input logic             resetn,
    phy_reset_seq_if.slave  bus
);

    if (LOCK_FILT < 2) begin : g_bad_filt
        $error("LOCK_FILT must be at least 2");
    end
    if (IDC_RST_CYC < 1 || SERDES_RST_CYC < 1 || RDY_TIMEOUT < 1) begin : g_bad_cyc
        $error("IDC_RST_CYC, SERDES_RST_CYC and RDY_TIMEOUT must be at least 1");
    end

    localparam int CW = $clog2(max3(LOCK_FILT, IDC_RST_CYC, SERDES_RST_CYC)) + 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] IDC_LAST  = CW'(IDC_RST_CYC);
    localparam logic [CW-1:0] SER_LAST  = CW'(SERDES_RST_CYC);

    seq_state_t       state;
    logic [CW-1:0]    cnt;
    phy_ctl_t         ctl;
    logic [CNT_W-1:0] loss_cnt;
    logic             lock_s;

`ifdef PHY_RST_TIMEOUT_EN
    localparam int TW = $clog2(RDY_TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(RDY_TIMEOUT);
    logic [TW-1:0] tcnt;
    logic          timeout_flag;
`endif

    sync_2ff u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.locked),
        .q      (lock_s)
    );

    // Lock loss outranks every in-state exit; only drops out of READY are counted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= HOLD;
            cnt      <= '0;
            ctl      <= ctl_for(HOLD);
            loss_cnt <= '0;
`ifdef PHY_RST_TIMEOUT_EN
            tcnt         <= '0;
            timeout_flag <= 1'b0;
`endif
        end else if (state != HOLD && !lock_s) begin
            state <= HOLD;
            cnt   <= '0;
            ctl   <= ctl_for(HOLD);
            if (state == READY && loss_cnt != '1) begin
                loss_cnt <= loss_cnt + 1'b1;
            end
        end else begin
            case (state)
                HOLD: begin
                    if (lock_s) begin
                        state <= FILTER;
                        cnt   <= CW'(1);
                        ctl   <= ctl_for(FILTER);
                    end
                end
                FILTER: begin
                    if (cnt == FILT_LAST) begin
                        state <= IDC_RST;
                        cnt   <= CW'(1);
                        ctl   <= ctl_for(IDC_RST);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDC_RST: begin
                    if (cnt == IDC_LAST) begin
                        state <= WAIT_RDY;
                        cnt   <= '0;
                        ctl   <= ctl_for(WAIT_RDY);
`ifdef PHY_RST_TIMEOUT_EN
                        tcnt  <= TW'(1);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (bus.idelay_rdy) begin
                        state <= SERDES_RST;
                        cnt   <= CW'(1);
                        ctl   <= ctl_for(SERDES_RST);
                    end
`ifdef PHY_RST_TIMEOUT_EN
                    else if (tcnt == TO_LAST) begin
                        state        <= HOLD;
                        ctl          <= ctl_for(HOLD);
                        timeout_flag <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                SERDES_RST: begin
                    if (cnt == SER_LAST) begin
                        state <= READY;
                        cnt   <= '0;
                        ctl   <= ctl_for(READY);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: ;
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                    ctl   <= ctl_for(HOLD);
                end
            endcase
        end
    end

    assign bus.idelayctrl_rst = ctl.idc_rst;
    assign bus.serdes_rst     = ctl.serdes_rst;
    assign bus.phy_ready      = ctl.ready;
    assign bus.lock_loss_cnt  = loss_cnt;
    assign bus.seq_state      = state;
`ifdef PHY_RST_TIMEOUT_EN
    assign bus.rdy_timeout    = timeout_flag;
`else
    assign bus.rdy_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_phy_reset_seq.sv
// Directed bench for phy_reset_seq; the WAIT_RDY timeout section follows PHY_RST_TIMEOUT_EN.
module tb_phy_reset_seq;
    import phy_pkg::*;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    phy_reset_seq_if #(.CNT_W(CNT_W)) bus ();

    phy_reset_seq #(
        .LOCK_FILT      (16),
        .IDC_RST_CYC    (8),
        .SERDES_RST_CYC (4),
        .RDY_TIMEOUT    (1024),
        .CNT_W          (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // k = edges since the synchroniser output first registered a high
    function automatic int exp_state(input int k);
        if (k <= 0)  return 0;
        if (k < 16)  return 1;
        if (k < 24)  return 2;
        if (k == 24) return 3;
        if (k < 29)  return 4;
        return 5;
    endfunction

    task automatic check_phase(input int k);
        check_output($sformatf("state_k%0d", k), 32'(bus.seq_state), 32'(exp_state(k)));
        check_output($sformatf("idc_rst_k%0d", k), 32'(bus.idelayctrl_rst), (k < 24) ? 32'd1 : 32'd0);
        check_output($sformatf("serdes_rst_k%0d", k), 32'(bus.serdes_rst), (k < 29) ? 32'd1 : 32'd0);
        check_output($sformatf("ready_k%0d", k), 32'(bus.phy_ready), (k >= 29) ? 32'd1 : 32'd0);
    endtask

    task automatic walk(input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++) begin
            step();
            check_phase(k);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_state"}, 32'(bus.seq_state), 32'd0);
        check_output({tag, "_idc"}, 32'(bus.idelayctrl_rst), 32'd1);
        check_output({tag, "_serdes"}, 32'(bus.serdes_rst), 32'd1);
        check_output({tag, "_ready"}, 32'(bus.phy_ready), 32'd0);
        check_output({tag, "_cnt"}, 32'(bus.lock_loss_cnt), 32'd0);
        check_output({tag, "_tmo"}, 32'(bus.rdy_timeout), 32'd0);
    endtask

    task automatic apply_stimulus_reset(input int cycles);
        resetn = 1'b0;
        step(cycles);
        check_reset_state("rst");
        resetn = 1'b1;
    endtask

    initial begin
        resetn         = 1'b0;
        bus.locked     = 1'b1;
        bus.idelay_rdy = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step();
            check_reset_state($sformatf("t1_c%0d", i));
        end
        resetn = 1'b1;

        // Release: sync output goes high on the second edge, then the 29-cycle walk.
        step();
        check_phase(0);
        step();
        check_phase(0);
        walk(1, 29);

        bus.idelay_rdy = 1'b0;
        step(3);
        check_output("rdy_drop_ready", 32'(bus.phy_ready), 32'd1);
        check_output("rdy_drop_state", 32'(bus.seq_state), 32'd5);
        bus.idelay_rdy = 1'b1;

        // One-cycle lock glitch while FILTER count is 10.
        apply_stimulus_reset(2);
        step(10);
        check_output("t3_filter", 32'(bus.seq_state), 32'd1);
        bus.locked = 1'b0;
        step();
        bus.locked = 1'b1;
        step();
        check_output("t3_filter_cnt10", 32'(bus.seq_state), 32'd1);
        step();
        check_phase(0);
        walk(1, 29);
        check_output("t3_loss_cnt", 32'(bus.lock_loss_cnt), 32'd0);

        // idelay_rdy held low for 50 cycles in WAIT_RDY.
        bus.idelay_rdy = 1'b0;
        apply_stimulus_reset(2);
        step();
        check_phase(0);
        step();
        check_phase(0);
        walk(1, 24);
        for (int i = 0; i < 50; i++) begin
            step();
            check_phase(24);
        end
        check_output("t4_tmo", 32'(bus.rdy_timeout), 32'd0);
        bus.idelay_rdy = 1'b1;
        step(4);
        check_output("t4_serdes_state", 32'(bus.seq_state), 32'd4);
        check_output("t4_ready_early", 32'(bus.phy_ready), 32'd0);
        step();
        check_output("t4_ready", 32'(bus.phy_ready), 32'd1);
        check_output("t4_serdes_rel", 32'(bus.serdes_rst), 32'd0);

        // Repeated lock loss from READY; counter saturates.
        for (int i = 0; i < 300; i++) begin
            bus.locked = 1'b0;
            step(2);
            check_output($sformatf("t5_hold_ready_%0d", i), 32'(bus.phy_ready), 32'd1);
            step();
            check_output($sformatf("t5_drop_ready_%0d", i), 32'(bus.phy_ready), 32'd0);
            check_output($sformatf("t5_drop_idc_%0d", i), 32'(bus.idelayctrl_rst), 32'd1);
            check_output($sformatf("t5_drop_serdes_%0d", i), 32'(bus.serdes_rst), 32'd1);
            check_output($sformatf("t5_cnt_%0d", i), 32'(bus.lock_loss_cnt), (i < 255) ? 32'(i + 1) : 32'd255);
            bus.locked = 1'b1;
            step(31);
            check_output($sformatf("t5_reup_%0d", i), 32'(bus.seq_state), 32'd5);
        end

        resetn = 1'b0;
        step();
        check_reset_state("mid_rst");
        bus.idelay_rdy = 1'b0;
        resetn = 1'b1;
        step();
        check_phase(0);
        step();
        check_phase(0);
        walk(1, 24);

`ifdef PHY_RST_TIMEOUT_EN
        step(1023);
        check_output("t6_still_wait", 32'(bus.seq_state), 32'd3);
        check_output("t6_tmo_early", 32'(bus.rdy_timeout), 32'd0);
        step();
        check_output("t6_tmo_state", 32'(bus.seq_state), 32'd0);
        check_output("t6_tmo_set", 32'(bus.rdy_timeout), 32'd1);
        check_output("t6_tmo_idc", 32'(bus.idelayctrl_rst), 32'd1);
        bus.idelay_rdy = 1'b1;
        walk(1, 29);
        check_output("t6_tmo_sticky", 32'(bus.rdy_timeout), 32'd1);
        check_output("t6_loss_cnt", 32'(bus.lock_loss_cnt), 32'd0);
        apply_stimulus_reset(2);
`else
        step(1100);
        check_output("t6_wait_forever", 32'(bus.seq_state), 32'd3);
        check_output("t6_tmo_tied", 32'(bus.rdy_timeout), 32'd0);
        apply_stimulus_reset(2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
